// File: rtl/gobang_win_checker.sv
// gobang_win_checker: after each placement, scans the row, column and both diagonals
// through the new stone for a run of WIN_LEN or more and reports winner, run endpoints and draw.
module gobang_win_checker #(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       clr,
    input  logic       check,
    input  logic [3:0] move_i,
    input  logic [3:0] move_j,
    input  logic       move_color,
    input  logic       retract,
    input  logic [8:0] black_i,
    input  logic [8:0] black_j,
    input  logic [8:0] black_ij,
    input  logic [8:0] black_ji,
    input  logic [8:0] white_i,
    input  logic [8:0] white_j,
    input  logic [8:0] white_ij,
    input  logic [8:0] white_ji,
    output logic [3:0] consider_i,
    output logic [3:0] consider_j,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       draw,
    output logic [3:0] row_first,
    output logic [3:0] row_last,
    output logic [3:0] col_first,
    output logic [3:0] col_last,
    output logic       line_en
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3, S_DONE} state_t;

    localparam logic [7:0] CELLS = 8'(BOARD_N * BOARD_N);

    state_t     r_state;
    logic [3:0] r_mi;
    logic [3:0] r_mj;
    logic       r_color;
    logic [7:0] r_cnt;
    logic [8:0] r_win [4];

    logic [2:0] w_sidx;
    logic [1:0] w_dir;
    logic [8:0] w_win;
    logic [2:0] w_l;
    logic [2:0] w_r;
    logic [4:0] w_len;
    logic       w_hit;
    logic       w_accept;
    logic [3:0] w_rf;
    logic [3:0] w_rl;
    logic [3:0] w_cf;
    logic [3:0] w_cl;

    // Length of the unbroken run of ones starting at v[0].
    function automatic logic [2:0] run_len(input logic [3:0] v);
        logic [2:0] n;
        logic       go;
        n  = 3'd0;
        go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            go = go & v[k];
            n  = n + {2'b00, go};
        end
        return n;
    endfunction

    assign w_sidx   = r_state - S_EVAL0;
    assign w_dir    = w_sidx[1:0];
    assign w_win    = r_win[w_dir];
    assign w_l      = run_len({w_win[0], w_win[1], w_win[2], w_win[3]});
    assign w_r      = run_len(w_win[8:5]);
    assign w_len    = 5'(w_l) + 5'(w_r) + 5'd1;
    assign w_hit    = w_len >= 5'(WIN_LEN);
    assign w_accept = check && winner == 2'b00 && !draw;

    // Endpoints walk back/forward along the direction's step; the counter diagonal steps j downward.
    assign w_rf = (w_dir == 2'd0) ? r_mi : r_mi - {1'b0, w_l};
    assign w_rl = (w_dir == 2'd0) ? r_mi : r_mi + {1'b0, w_r};
    assign w_cf = (w_dir == 2'd1) ? r_mj : (w_dir == 2'd3) ? r_mj + {1'b0, w_l} : r_mj - {1'b0, w_l};
    assign w_cl = (w_dir == 2'd1) ? r_mj : (w_dir == 2'd3) ? r_mj - {1'b0, w_r} : r_mj + {1'b0, w_r};

    always_ff @(posedge clk) begin
        if (rst_p || clr) begin
            r_state    <= S_IDLE;
            r_mi       <= 4'd0;
            r_mj       <= 4'd0;
            r_color    <= 1'b0;
            r_cnt      <= 8'd0;
            consider_i <= 4'd0;
            consider_j <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= 2'b00;
            draw       <= 1'b0;
            row_first  <= 4'd0;
            row_last   <= 4'd0;
            col_first  <= 4'd0;
            col_last   <= 4'd0;
            line_en    <= 1'b0;
        end else if (retract) begin
            r_state <= S_IDLE;
            r_cnt   <= (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= 2'b00;
            draw    <= 1'b0;
            line_en <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mi       <= move_i;
                        r_mj       <= move_j;
                        r_color    <= move_color;
                        consider_i <= move_i;
                        consider_j <= move_j;
                        r_cnt      <= r_cnt + 8'd1;
                        busy       <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_win[0] <= r_color ? white_i  : black_i;
                    r_win[1] <= r_color ? white_j  : black_j;
                    r_win[2] <= r_color ? white_ij : black_ij;
                    r_win[3] <= r_color ? white_ji : black_ji;
                    r_state  <= S_EVAL0;
                end
                S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3: begin
                    if (w_hit) begin
                        winner    <= r_color ? 2'b01 : 2'b10;
                        line_en   <= 1'b1;
                        row_first <= w_rf;
                        row_last  <= w_rl;
                        col_first <= w_cf;
                        col_last  <= w_cl;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_state == S_EVAL3) begin
                        draw    <= r_cnt == CELLS;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= state_t'(r_state + 3'd1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gobang_win_checker.sv
// tb_gobang_win_checker: board-level model of the win checker, compared against the DUT every cycle,
// plus directed games with hand-computed results.
module tb_gobang_win_checker;
    logic       clk = 1'b0;
    logic       rst_p, clr, check, move_color, retract;
    logic [3:0] move_i, move_j;
    logic [8:0] black_i, black_j, black_ij, black_ji;
    logic [8:0] white_i, white_j, white_ij, white_ji;
    logic [3:0] consider_i, consider_j, row_first, row_last, col_first, col_last;
    logic       busy, done, draw, line_en;
    logic [1:0] winner;

    bit bb [15][15];
    bit bw [15][15];
    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    int         m_phase = 0, m_lat = 0, m_cnt = 0;
    logic [1:0] p_w, e_winner = 2'b00;
    int         p_rf, p_rl, p_cf, p_cl;
    int         e_rf = 0, e_rl = 0, e_cf = 0, e_cl = 0, e_ci = 0, e_cj = 0;
    bit         e_line = 1'b0, e_draw = 1'b0;

    always #5 clk = ~clk;

    gobang_win_checker dut (
        .clk(clk), .rst_p(rst_p), .clr(clr), .check(check),
        .move_i(move_i), .move_j(move_j), .move_color(move_color), .retract(retract),
        .black_i(black_i), .black_j(black_j), .black_ij(black_ij), .black_ji(black_ji),
        .white_i(white_i), .white_j(white_j), .white_ij(white_ij), .white_ji(white_ji),
        .consider_i(consider_i), .consider_j(consider_j), .busy(busy), .done(done),
        .winner(winner), .draw(draw), .row_first(row_first), .row_last(row_last),
        .col_first(col_first), .col_last(col_last), .line_en(line_en)
    );

    function automatic bit stone(input int i, input int j, input bit c);
        if (i < 0 || i > 14 || j < 0 || j > 14) return 1'b0;
        return c ? bw[i][j] : bb[i][j];
    endfunction

    // Walk the board from the new stone in each direction; a 9-cell window sees at most 4 per side.
    function automatic void model_eval(input int mi, input int mj, input bit c, output int lat,
                                       output logic [1:0] w, output int rf, output int rl,
                                       output int cf, output int cl);
        int di [4];
        int dj [4];
        int l, r;
        di = '{0, 1, 1, 1};
        dj = '{1, 0, 1, -1};
        w = 2'b00; lat = 6; rf = 0; rl = 0; cf = 0; cl = 0;
        for (int d = 0; d < 4; d++) begin
            l = 0;
            while (l < 4 && stone(mi - (l + 1) * di[d], mj - (l + 1) * dj[d], c)) l++;
            r = 0;
            while (r < 4 && stone(mi + (r + 1) * di[d], mj + (r + 1) * dj[d], c)) r++;
            if (l + r + 1 >= 5) begin
                w = c ? 2'b01 : 2'b10;
                lat = 3 + d;
                rf = mi - l * di[d]; cf = mj - l * dj[d];
                rl = mi + r * di[d]; cl = mj + r * dj[d];
                return;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Board store: windows follow consider_* and are stable well before the capturing edge.
    always @(negedge clk) begin
        for (int k = 0; k < 9; k++) begin
            int ci, cj, d;
            ci = int'(consider_i);
            cj = int'(consider_j);
            d  = k - 4;
            black_i[k]  = stone(ci, cj + d, 1'b0);
            white_i[k]  = stone(ci, cj + d, 1'b1);
            black_j[k]  = stone(ci + d, cj, 1'b0);
            white_j[k]  = stone(ci + d, cj, 1'b1);
            black_ij[k] = stone(ci + d, cj + d, 1'b0);
            white_ij[k] = stone(ci + d, cj + d, 1'b1);
            black_ji[k] = stone(ci + d, cj - d, 1'b0);
            white_ji[k] = stone(ci + d, cj - d, 1'b1);
        end
    end

    // Timeline model: m_phase counts cycles since an accepted check; results land at m_lat.
    always @(posedge clk) begin
        if (rst_p || clr) begin
            m_phase = 0; m_cnt = 0; e_winner = 2'b00; e_line = 1'b0; e_draw = 1'b0;
            e_rf = 0; e_rl = 0; e_cf = 0; e_cl = 0; e_ci = 0; e_cj = 0;
        end else if (retract) begin
            m_phase = 0; e_winner = 2'b00; e_line = 1'b0; e_draw = 1'b0;
            if (m_cnt > 0) m_cnt--;
        end else if (m_phase == 0) begin
            if (check && e_winner == 2'b00 && !e_draw) begin
                m_cnt++;
                e_ci = int'(move_i);
                e_cj = int'(move_j);
                model_eval(int'(move_i), int'(move_j), move_color, m_lat, p_w, p_rf, p_rl, p_cf, p_cl);
                m_phase = 1;
            end
        end else begin
            m_phase++;
            if (m_phase == m_lat) begin
                if (p_w != 2'b00) begin
                    e_winner = p_w; e_line = 1'b1;
                    e_rf = p_rf; e_rl = p_rl; e_cf = p_cf; e_cl = p_cl;
                end else begin
                    e_draw = (m_cnt == 225);
                end
            end else if (m_phase > m_lat) begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, m_phase >= 1 && m_phase < m_lat);
            chk("done", done, m_phase != 0 && m_phase == m_lat);
            chk("winner", winner, e_winner);
            chk("line_en", line_en, e_line);
            chk("draw", draw, e_draw);
            chk("consider_i", consider_i, e_ci);
            chk("consider_j", consider_j, e_cj);
            if (e_line) begin
                chk("row_first", row_first, e_rf);
                chk("row_last", row_last, e_rl);
                chk("col_first", col_first, e_cf);
                chk("col_last", col_last, e_cl);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse check and return the cycle (relative to the sampling edge) of the done pulse, -1 if none.
    task automatic issue(input int i, input int j, input bit c, output int lat);
        move_i = 4'(i); move_j = 4'(j); move_color = c; check = 1'b1;
        tick(1);
        check = 1'b0;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done && lat < 0) lat = n;
            tick(1);
            if (lat >= 0) break;
        end
    endtask

    task automatic new_game();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                bb[i][j] = 1'b0;
                bw[i][j] = 1'b0;
            end
    endtask

    task automatic pulse_retract();
        retract = 1'b1;
        tick(1);
        retract = 1'b0;
    endtask

    task automatic quiet(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            seen |= done;
            tick(1);
        end
        chk(name, seen, 1'b0);
    endtask

    initial begin
        int lat;
        rst_p = 1'b1; clr = 1'b0; check = 1'b0; retract = 1'b0;
        move_i = 4'd0; move_j = 4'd0; move_color = 1'b0;
        tick(2);
        rst_p = 1'b0;
        armed = 1'b1;
        chk("reset_winner", winner, 0);
        chk("reset_busy", busy, 0);
        chk("reset_consider", {consider_i, consider_j}, 0);

        for (int j = 3; j <= 7; j++) bb[7][j] = 1'b1;
        issue(7, 7, 1'b0, lat);
        chk("row_lat", lat, 3);
        chk("row_winner", winner, 2'b10);
        chk("row_rf", row_first, 7);
        chk("row_rl", row_last, 7);
        chk("row_cf", col_first, 3);
        chk("row_cl", col_last, 7);
        chk("row_line_en", line_en, 1);

        pulse_retract();
        chk("retract_winner", winner, 0);
        chk("retract_line_en", line_en, 0);
        issue(7, 7, 1'b0, lat);
        chk("rewin_lat", lat, 3);
        chk("rewin_winner", winner, 2'b10);

        new_game();
        bw[2][10] = 1'b1; bw[3][9] = 1'b1; bw[4][8] = 1'b1; bw[5][7] = 1'b1; bw[6][6] = 1'b1;
        issue(4, 8, 1'b1, lat);
        chk("anti_lat", lat, 6);
        chk("anti_winner", winner, 2'b01);
        chk("anti_rf", row_first, 2);
        chk("anti_cf", col_first, 10);
        chk("anti_rl", row_last, 6);
        chk("anti_cl", col_last, 6);

        new_game();
        for (int j = 0; j <= 3; j++) bb[0][j] = 1'b1;
        issue(0, 3, 1'b0, lat);
        chk("four_lat", lat, 6);
        chk("four_winner", winner, 0);
        chk("four_line_en", line_en, 0);
        bb[0][4] = 1'b1;
        issue(0, 4, 1'b0, lat);
        chk("edge_lat", lat, 3);
        chk("edge_cf", col_first, 0);
        chk("edge_cl", col_last, 4);
        chk("edge_rf", row_first, 0);

        new_game();
        for (int i = 5; i <= 10; i++) bb[i][2] = 1'b1;
        issue(8, 2, 1'b0, lat);
        chk("over_lat", lat, 4);
        chk("over_rf", row_first, 5);
        chk("over_rl", row_last, 10);
        chk("over_cf", col_first, 2);

        pulse_retract();
        move_i = 4'd9; move_j = 4'd9; move_color = 1'b0; check = 1'b1;
        tick(1);
        check = 1'b0;
        chk("read_busy", busy, 1);
        rst_p = 1'b1;
        tick(1);
        rst_p = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_consider", {consider_i, consider_j}, 0);
        chk("rst_endpoints", {row_first, row_last, col_first, col_last}, 0);
        chk("rst_flags", {winner, draw, line_en}, 0);

        new_game();
        move_i = 4'd3; move_j = 4'd3; check = 1'b1;
        tick(1);
        check = 1'b0;
        tick(2);
        retract = 1'b1;
        tick(1);
        retract = 1'b0;
        chk("abort_busy", busy, 0);
        quiet("abort_no_done");

        new_game();
        for (int k = 0; k < 225; k++) begin
            issue(k / 15, k % 15, k[0], lat);
            if (k == 224) chk("draw_lat", lat, 6);
        end
        chk("draw_set", draw, 1);
        chk("draw_winner", winner, 0);
        issue(0, 0, 1'b0, lat);
        chk("draw_ignored_lat", lat, -1);
        chk("draw_hold", draw, 1);

        move_i = 4'd0; move_j = 4'd0; check = 1'b1; retract = 1'b1;
        tick(1);
        check = 1'b0; retract = 1'b0;
        chk("both_draw_clr", draw, 0);
        quiet("both_no_done");
        issue(1, 1, 1'b0, lat);
        chk("redraw_lat", lat, 6);
        chk("redraw_set", draw, 1);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
